sd_fifo_filler_burst: RTL and testbench

- Wishbone read-DMA master that moves a programmed number of words from system memory into the SD TX data FIFO ahead of the serial data path.
- Successor to the single-beat TX filler, with these additions:
  - parametrised data/address width and burst length;
  - incrementing-burst cycles (CTI/BTE);
  - an explicit transfer length with done status;
  - bus-error handling;
  - space-checked bursts against an external FIFO free-count.
- Single clock domain. The FIFO instance and its clock crossing sit outside this block.

---
 rtl/sd_fifo_filler_burst.sv | 97 +++++++++
 tb/tb_sd_fifo_filler_burst.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/sd_fifo_filler_burst.sv
// sd_fifo_filler_burst: Wishbone burst read-DMA master filling the SD TX data FIFO
module sd_fifo_filler_burst #(
    parameter int DW        = 32,
    parameter int AW        = 32,
    parameter int BURST_LEN = 4,
    parameter int LEN_W     = 16,
    parameter int FREE_W    = 5,
    parameter int ADR_INC   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [AW-1:0]     start_adr,
    input  logic [LEN_W-1:0]  xfer_words,
    output logic [AW-1:0]     m_wb_adr_o,
    input  logic [DW-1:0]     m_wb_dat_i,
    output logic [DW/8-1:0]   m_wb_sel_o,
    output logic              m_wb_we_o,
    output logic              m_wb_cyc_o,
    output logic              m_wb_stb_o,
    output logic [2:0]        m_wb_cti_o,
    output logic [1:0]        m_wb_bte_o,
    input  logic              m_wb_ack_i,
    input  logic              m_wb_err_i,
    output logic [DW-1:0]     fifo_din,
    output logic              fifo_wr,
    input  logic [FREE_W-1:0] fifo_free,
    output logic              busy,
    output logic              done,
    output logic              bus_err
);
    localparam int BW = $clog2(BURST_LEN) + 1;

    typedef enum logic [2:0] {IDLE, WAIT_SPACE, BURST, DONE, ERROR} state_t;

    state_t           state, state_nx;
    logic [AW-1:0]    addr;
    logic [LEN_W-1:0] remaining, blen;
    logic [BW-1:0]    beats;
    logic             last, space_ok;

    // Bus and status outputs decode straight from the state register, so reset clears them at once
    assign m_wb_cyc_o = state == BURST;
    assign m_wb_stb_o = state == BURST;
    assign m_wb_cti_o = state != BURST ? 3'b000 : last ? 3'b111 : 3'b010;
    assign m_wb_adr_o = addr;
    assign m_wb_sel_o = '1;
    assign m_wb_we_o  = 1'b0;
    assign m_wb_bte_o = 2'b00;
    assign fifo_din   = m_wb_dat_i;
    assign fifo_wr    = state == BURST && m_wb_ack_i && !m_wb_err_i;
    assign busy       = state == WAIT_SPACE || state == BURST;
    assign done       = state == DONE;
    assign bus_err    = state == ERROR;

    // Next-state logic; a burst is only launched once the FIFO can absorb all of it
    always_comb begin
        state_nx = state;
        blen     = remaining < LEN_W'(BURST_LEN) ? remaining : LEN_W'(BURST_LEN);
        space_ok = 32'(fifo_free) >= 32'(blen);
        last     = beats == BW'(1);
        if (!en)
            state_nx = IDLE;
        else
            case (state)
                IDLE:       state_nx = xfer_words == '0 ? DONE : WAIT_SPACE;
                WAIT_SPACE: state_nx = space_ok ? BURST : WAIT_SPACE;
                BURST:      state_nx = m_wb_err_i ? ERROR :
                                       !(m_wb_ack_i && last) ? BURST :
                                       remaining == LEN_W'(1) ? DONE : WAIT_SPACE;
                default:    state_nx = state;
            endcase
    end

    // State register plus address, remaining-word and beat counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            addr      <= '0;
            remaining <= '0;
            beats     <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && en) begin
                addr      <= start_adr;
                remaining <= xfer_words;
            end
            if (state == WAIT_SPACE)
                beats <= BW'(blen);
            if (fifo_wr) begin
                addr      <= addr + AW'(ADR_INC);
                remaining <= remaining - LEN_W'(1);
                beats     <= beats - BW'(1);
            end
        end
    end
endmodule

// File: tb/tb_sd_fifo_filler_burst.sv
// tb_sd_fifo_filler_burst: random and directed DMA transfers checked against a word-list model
module tb_sd_fifo_filler_burst;
    localparam int DW = 32, AW = 32, BL = 4, LEN_W = 16, FREE_W = 5, INC = 4;

    logic clk = 0, rst = 0, en = 0;
    logic [AW-1:0] start_adr = '0;
    logic [LEN_W-1:0] xfer_words = '0;
    logic [AW-1:0] adr;
    logic [DW-1:0] dat = '0, fifo_din;
    logic [DW/8-1:0] sel;
    logic we, cyc, stb, ack = 0, err = 0, fifo_wr, busy, done, bus_err;
    logic [2:0] cti;
    logic [1:0] bte;
    logic [FREE_W-1:0] fifo_free = 16;

    int checks = 0, errors = 0;
    logic [AW-1:0] base = '0;
    int n = 0, k = 0, k0 = 0, acks = 0, acks0 = 0, err_at = -1, wait_pct = 0, cyc_cnt = 0;
    bit free_rand = 0, gap_due = 0, prev_cyc = 0;
    logic [FREE_W-1:0] prev_free = '0;

    sd_fifo_filler_burst #(.DW(DW), .AW(AW), .BURST_LEN(BL), .LEN_W(LEN_W), .FREE_W(FREE_W), .ADR_INC(INC)) dut (
        .clk(clk), .rst(rst), .en(en), .start_adr(start_adr), .xfer_words(xfer_words),
        .m_wb_adr_o(adr), .m_wb_dat_i(dat), .m_wb_sel_o(sel), .m_wb_we_o(we), .m_wb_cyc_o(cyc),
        .m_wb_stb_o(stb), .m_wb_cti_o(cti), .m_wb_bte_o(bte), .m_wb_ack_i(ack), .m_wb_err_i(err),
        .fifo_din(fifo_din), .fifo_wr(fifo_wr), .fifo_free(fifo_free),
        .busy(busy), .done(done), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] mem(input logic [AW-1:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    function automatic int chunk(input int left);
        return left < BL ? left : BL;
    endfunction

    // Memory slave: random wait states, data derived from address, error injected on a chosen beat
    always @(posedge clk) begin
        #1;
        if (free_rand) fifo_free = FREE_W'($urandom_range(0, 16));
        if (cyc && stb && $urandom_range(0, 99) >= wait_pct) begin
            err = (acks - acks0) == err_at;
            ack = !err || $urandom_range(0, 1) == 1;
            dat = mem(adr);
            if (!err) acks++;
        end else begin
            ack = 0;
            err = 0;
            dat = $urandom;
        end
    end

    // Monitor: every FIFO write must be the next word of the transfer, with burst framing and space rules
    always @(negedge clk) begin
        if (rst) begin
            int idx, pos, csz;
            logic [AW-1:0] ea;
            idx = k - k0;
            if (gap_due) begin
                check("gap", cyc, 0);
                gap_due = 0;
            end
            if (cyc && !prev_cyc) check("space", 64'(prev_free >= FREE_W'(chunk(n - idx))), 1);
            if (cyc) cyc_cnt++;
            if (cyc && err) gap_due = 1;
            if (fifo_wr) begin
                ea = base + AW'(idx * INC);
                pos = idx % BL;
                csz = chunk(n - (idx - pos));
                check("wr_adr", adr, ea);
                check("wr_dat", fifo_din, mem(ea));
                check("cti", cti, pos == csz - 1 ? 3'b111 : 3'b010);
                check("static", {sel, we, bte}, {4'hF, 1'b0, 2'b00});
                if (pos == csz - 1) gap_due = 1;
                k++;
            end
            prev_cyc = cyc;
            prev_free = fifo_free;
        end
    end

    task automatic start(input logic [AW-1:0] a, input int words, input int eat);
        @(posedge clk); #2;
        base = a; n = words; k0 = k; acks0 = acks; err_at = eat;
        start_adr = a; xfer_words = LEN_W'(words); en = 1;
    endtask

    task automatic finish(input int words, input int eat);
        int cnt = 0, c0;
        bit exp_err;
        c0 = cyc_cnt;
        exp_err = eat >= 0 && eat < words;
        while (!(done || bus_err) && cnt < 3000) begin
            @(posedge clk); #2;
            cnt++;
        end
        if (cnt >= 3000) check("timeout", 0, 1);
        if (words == 0) begin
            check("zero_lat", cnt, 1);
            check("zero_nocyc", cyc_cnt - c0, 0);
        end
        check("done", done, !exp_err);
        check("bus_err", bus_err, exp_err);
        check("busy_end", busy, 0);
        check("words", k - k0, exp_err ? eat : words);
        en = 0;
        @(posedge clk); #2;
        check("idle_status", {done, bus_err, busy, cyc}, 0);
    endtask

    task automatic run(input logic [AW-1:0] a, input int words, input int eat);
        start(a, words, eat);
        finish(words, eat);
    endtask

    initial begin
        int cnt;
        repeat (3) @(posedge clk);
        #2;
        check("rst_out", {cyc, stb, we, cti, adr, busy, done, bus_err, fifo_wr}, 0);
        rst = 1;
        run(32'h1000, 8, -1);
        run(32'h1000, 6, -1);
        fifo_free = 3;
        start(32'h3000, 8, -1);
        repeat (5) begin
            @(posedge clk); #2;
            check("hold_cyc", {cyc, busy}, 2'b01);
        end
        fifo_free = 4;
        @(posedge clk); #2;
        check("start_cyc", cyc, 1);
        finish(8, -1);
        fifo_free = 16;
        run(32'h4000, 8, 2);
        run(32'h5000, 0, -1);
        start(32'h6000, 8, -1);
        cnt = 0;
        while (k - k0 < 1 && cnt < 100) begin
            @(posedge clk); #2;
            cnt++;
        end
        en = 0;
        @(posedge clk); #2;
        check("abort_bus", {cyc, stb, busy}, 0);
        check("abort_words", k - k0, 2);
        run(32'h2000, 5, -1);
        free_rand = 1;
        for (int t = 0; t < 24; t++) begin
            int w, e;
            logic [AW-1:0] a;
            wait_pct = $urandom_range(0, 50);
            w = $urandom_range(0, 20);
            e = $urandom_range(0, 3) == 0 ? $urandom_range(0, w) : -1;
            a = t % 4 == 0 ? 32'hFFFF_FFF0 : {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
            run(a, w, e);
        end
        free_rand = 0;
        fifo_free = 16;
        wait_pct = 0;
        start(32'h7000, 8, -1);
        cnt = 0;
        while (k - k0 < 1 && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        #2;
        rst = 0;
        #1;
        check("async_rst", {cyc, stb, busy, adr, cti}, 0);
        en = 0;
        @(posedge clk); #2;
        rst = 1;
        @(posedge clk); #2;
        check("post_rst", {cyc, done, bus_err}, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
